// File: rtl/csr_to_mbram_bridge_pkg.sv
// Shared types and helpers for the CSR to multi-bank RAM bridge.
package csr_to_mbram_bridge_pkg;

   // Widest word the helpers handle; callers zero-extend narrower words.
   localparam int unsigned MAX_WORD_BITS = 32'd1024;
   localparam int unsigned MAX_BYTES     = MAX_WORD_BITS / 32'd8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_WAIT  = 3'd1,
      ST_RMW_WAIT = 3'd2,
      ST_RMW_WR   = 3'd3,
      ST_DONE     = 3'd4
   } bridge_state_e;

   typedef struct packed {
      logic [MAX_BYTES-1:0] byte_en;  // lanes whose eight enable bits are all set
      logic                 partial;  // some lane has a mix of set and clear bits
   } byte_en_t;

   // Classify each byte lane of a per-bit enable as full, empty or partial.
   function automatic byte_en_t to_byte_en(input logic [MAX_WORD_BITS-1:0] bit_en);
      byte_en_t res;
      res.byte_en = '0;
      res.partial = 1'b0;
      for (int i = 0; i < int'(MAX_BYTES); i++) begin
         if (bit_en[i*8 +: 8] == 8'hFF) begin
            res.byte_en[i] = 1'b1;
         end else if (bit_en[i*8 +: 8] != 8'h00) begin
            res.partial = 1'b1;
         end else begin
            res.byte_en[i] = 1'b0;
         end
      end
      return res;
   endfunction

   // Bitwise merge: enabled bits come from new_word, the rest from old_word.
   function automatic logic [MAX_WORD_BITS-1:0] merge_bits(
      input logic [MAX_WORD_BITS-1:0] old_word,
      input logic [MAX_WORD_BITS-1:0] new_word,
      input logic [MAX_WORD_BITS-1:0] bit_en);
      return (old_word & ~bit_en) | (new_word & bit_en);
   endfunction

endpackage

// File: rtl/csr_to_mbram_bridge_rd_lat_timer.sv
// Down-counter that times the RAM read latency; done once it has run out.
module rd_lat_timer #(
   parameter  int unsigned MAX_LAT = 32'd8,
   localparam int unsigned CNT_W   = $clog2(MAX_LAT + 32'd1)
)(
   input  logic i_clk,
   input  logic i_async_rst_n,
   input  logic i_load,
   input  logic i_count,
   output logic o_done
);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   // Next count: reload on request, otherwise count down and stop at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (i_load) begin
         cnt_d = CNT_W'(MAX_LAT);
      end else if (i_count && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register, cleared by reset.
   always_ff @(posedge i_clk or negedge i_async_rst_n) begin
      if (!i_async_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_done = (cnt_q == '0);

endmodule

// File: rtl/csr_to_mbram_bridge.sv
// Bridges single-word CSR accesses onto a set of RAM banks, doing a
// read-modify-write whenever a write enables only part of a byte lane.
module csr_to_mbram_bridge
   import csr_to_mbram_bridge_pkg::*;
#(
   parameter  int unsigned WORD_BIT_WIDTH      = 32'd32,
   parameter  int unsigned NUM_BANKS           = 32'd3,
   parameter  int unsigned BANK_DEPTH          = 32'd8,
   parameter  int unsigned RAM_RD_LATENCY      = 32'd2,
   localparam int unsigned BYTES               = WORD_BIT_WIDTH / 32'd8,
   localparam int unsigned LB_W                = $clog2(BYTES),
   localparam int unsigned WA_W                = $clog2(BANK_DEPTH),
   localparam int unsigned BK_W                = (NUM_BANKS > 32'd1) ? $clog2(NUM_BANKS) : 32'd1,
   localparam int unsigned BYTE_ADDR_BIT_WIDTH = BK_W + WA_W + LB_W
)(
   input  logic                                i_clk,
   input  logic                                i_async_rst_n,
   input  logic                                i_acc_req,
   input  logic [BYTE_ADDR_BIT_WIDTH-1:0]      i_byte_addr,
   input  logic                                i_acc_req_is_wr,
   input  logic [WORD_BIT_WIDTH-1:0]           i_wr_data,
   input  logic [WORD_BIT_WIDTH-1:0]           i_wr_bit_en,
   output logic                                o_rd_ack,
   output logic                                o_wr_ack,
   output logic                                o_err,
   output logic [WORD_BIT_WIDTH-1:0]           o_rd_data,
   output logic                                o_busy,
   output logic [NUM_BANKS-1:0]                o_ram_we,
   output logic [NUM_BANKS-1:0]                o_ram_re,
   output logic [WA_W-1:0]                     o_ram_word_addr,
   output logic [WORD_BIT_WIDTH-1:0]           o_ram_wr_data,
   output logic [BYTES-1:0]                    o_ram_wr_byte_en,
   input  logic [NUM_BANKS*WORD_BIT_WIDTH-1:0] i_ram_rd_data
);

   if ((WORD_BIT_WIDTH < 32'd8) || ((WORD_BIT_WIDTH & (WORD_BIT_WIDTH - 32'd1)) != 32'd0) ||
       (WORD_BIT_WIDTH > MAX_WORD_BITS / 32'd2)) begin : g_bad_word_width
      $error("csr_to_mbram_bridge: WORD_BIT_WIDTH must be a power of 2, 8..%0d", MAX_WORD_BITS / 2);
   end
   if ((NUM_BANKS < 32'd1) || (NUM_BANKS > 32'd16)) begin : g_bad_num_banks
      $error("csr_to_mbram_bridge: NUM_BANKS must be 1..16");
   end
   if ((BANK_DEPTH < 32'd2) || ((BANK_DEPTH & (BANK_DEPTH - 32'd1)) != 32'd0)) begin : g_bad_depth
      $error("csr_to_mbram_bridge: BANK_DEPTH must be a power of 2, at least 2");
   end
   if ((RAM_RD_LATENCY < 32'd1) || (RAM_RD_LATENCY > 32'd8)) begin : g_bad_latency
      $error("csr_to_mbram_bridge: RAM_RD_LATENCY must be 1..8");
   end

   bridge_state_e               state_d, state_q;
   logic                        ready_d, ready_q;
   logic [BK_W-1:0]             bank_d, bank_q;
   logic [WA_W-1:0]             word_d, word_q;
   logic [WORD_BIT_WIDTH-1:0]   wdata_d, wdata_q;
   logic [WORD_BIT_WIDTH-1:0]   bit_en_d, bit_en_q;
   logic [NUM_BANKS-1:0]        ram_we_d, ram_we_q, ram_re_d, ram_re_q;
   logic [WA_W-1:0]             ram_word_addr_d, ram_word_addr_q;
   logic [WORD_BIT_WIDTH-1:0]   ram_wr_data_d, ram_wr_data_q;
   logic [BYTES-1:0]            ram_wr_byte_en_d, ram_wr_byte_en_q;
   logic                        rd_ack_d, rd_ack_q, wr_ack_d, wr_ack_q, err_d, err_q, busy_d, busy_q;
   logic [WORD_BIT_WIDTH-1:0]   rd_data_d, rd_data_q;

   logic [BK_W-1:0]             bank_in_s;
   logic [WA_W-1:0]             word_in_s;
   logic                        in_range_s;
   logic [NUM_BANKS-1:0]        hot_in_s, hot_q_s;
   logic [MAX_WORD_BITS-1:0]    be_in_ext_s, old_ext_s, wdata_ext_s, be_q_ext_s, merged_ext_s;
   byte_en_t                    be_in_s;
   logic [BYTES-1:0]            be_lanes_s;
   logic [WORD_BIT_WIDTH-1:0]   bank_rd_s, merged_s;
   logic                        tmr_load_s, tmr_count_s, tmr_done_s;
   logic                        unused_bits_s;

   assign bank_in_s  = i_byte_addr[BYTE_ADDR_BIT_WIDTH-1 -: BK_W];
   assign word_in_s  = i_byte_addr[LB_W +: WA_W];
   assign in_range_s = ({1'b0, bank_in_s} < (BK_W + 1)'(NUM_BANKS));
   assign hot_in_s   = NUM_BANKS'(1'b1) << bank_in_s;
   assign hot_q_s    = NUM_BANKS'(1'b1) << bank_q;

   // Select the addressed bank's read data and widen words for the helpers.
   always_comb begin
      bank_rd_s = '0;
      for (int k = 0; k < int'(NUM_BANKS); k++) begin
         bank_rd_s = bank_rd_s | ((bank_q == BK_W'(k)) ?
                     i_ram_rd_data[k*WORD_BIT_WIDTH +: WORD_BIT_WIDTH] : '0);
      end
      be_in_ext_s = '0;
      be_in_ext_s[WORD_BIT_WIDTH-1:0] = i_wr_bit_en;
      old_ext_s   = '0;
      old_ext_s[WORD_BIT_WIDTH-1:0] = bank_rd_s;
      wdata_ext_s = '0;
      wdata_ext_s[WORD_BIT_WIDTH-1:0] = wdata_q;
      be_q_ext_s  = '0;
      be_q_ext_s[WORD_BIT_WIDTH-1:0] = bit_en_q;
   end

   assign be_in_s       = to_byte_en(be_in_ext_s);
   assign be_lanes_s    = be_in_s.byte_en[BYTES-1:0];
   assign merged_ext_s  = merge_bits(old_ext_s, wdata_ext_s, be_q_ext_s);
   assign merged_s      = merged_ext_s[WORD_BIT_WIDTH-1:0];
   assign unused_bits_s = ^{i_byte_addr, be_in_s, merged_ext_s};
   assign ready_d       = 1'b1;

   rd_lat_timer #(
      .MAX_LAT (RAM_RD_LATENCY)
   ) u_rd_lat_timer (
      .i_clk         (i_clk),
      .i_async_rst_n (i_async_rst_n),
      .i_load        (tmr_load_s),
      .i_count       (tmr_count_s),
      .o_done        (tmr_done_s)
   );

   // Next-state and next-output logic; strobes and acks default to idle.
   always_comb begin
      state_d          = state_q;
      bank_d           = bank_q;
      word_d           = word_q;
      wdata_d          = wdata_q;
      bit_en_d         = bit_en_q;
      ram_we_d         = '0;
      ram_re_d         = '0;
      ram_word_addr_d  = ram_word_addr_q;
      ram_wr_data_d    = ram_wr_data_q;
      ram_wr_byte_en_d = ram_wr_byte_en_q;
      rd_ack_d         = 1'b0;
      wr_ack_d         = 1'b0;
      err_d            = 1'b0;
      rd_data_d        = rd_data_q;
      tmr_load_s       = 1'b0;
      tmr_count_s      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_acc_req && ready_q) begin
               bank_d   = bank_in_s;
               word_d   = word_in_s;
               wdata_d  = i_wr_data;
               bit_en_d = i_wr_bit_en;
               state_d  = ST_DONE;
               if (!in_range_s) begin
                  err_d    = 1'b1;
                  wr_ack_d = i_acc_req_is_wr;
                  rd_ack_d = !i_acc_req_is_wr;
                  rd_data_d = i_acc_req_is_wr ? rd_data_q : '0;
               end else if (!i_acc_req_is_wr || be_in_s.partial) begin
                  // Reads and partial-lane writes both start by reading the word.
                  ram_re_d        = hot_in_s;
                  ram_word_addr_d = word_in_s;
                  tmr_load_s      = 1'b1;
                  state_d         = i_acc_req_is_wr ? ST_RMW_WAIT : ST_RD_WAIT;
               end else if (be_lanes_s == '0) begin
                  wr_ack_d = 1'b1;
               end else begin
                  ram_we_d         = hot_in_s;
                  ram_word_addr_d  = word_in_s;
                  ram_wr_data_d    = i_wr_data;
                  ram_wr_byte_en_d = be_lanes_s;
                  wr_ack_d         = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD_WAIT: begin
            tmr_count_s = 1'b1;
            if (tmr_done_s) begin
               rd_data_d = bank_rd_s;
               rd_ack_d  = 1'b1;
               state_d   = ST_DONE;
            end else begin
               state_d = ST_RD_WAIT;
            end
         end
         ST_RMW_WAIT: begin
            tmr_count_s = 1'b1;
            if (tmr_done_s) begin
               ram_we_d         = hot_q_s;
               ram_word_addr_d  = word_q;
               ram_wr_data_d    = merged_s;
               ram_wr_byte_en_d = {BYTES{1'b1}};
               wr_ack_d         = 1'b1;
               state_d          = ST_RMW_WR;
            end else begin
               state_d = ST_RMW_WAIT;
            end
         end
         ST_RMW_WR: state_d = ST_IDLE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State, latched request and registered outputs, all cleared by reset.
   always_ff @(posedge i_clk or negedge i_async_rst_n) begin
      if (!i_async_rst_n) begin
         state_q          <= ST_IDLE;
         ready_q          <= 1'b0;
         bank_q           <= '0;
         word_q           <= '0;
         wdata_q          <= '0;
         bit_en_q         <= '0;
         ram_we_q         <= '0;
         ram_re_q         <= '0;
         ram_word_addr_q  <= '0;
         ram_wr_data_q    <= '0;
         ram_wr_byte_en_q <= '0;
         rd_ack_q         <= 1'b0;
         wr_ack_q         <= 1'b0;
         err_q            <= 1'b0;
         rd_data_q        <= '0;
         busy_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         ready_q          <= ready_d;
         bank_q           <= bank_d;
         word_q           <= word_d;
         wdata_q          <= wdata_d;
         bit_en_q         <= bit_en_d;
         ram_we_q         <= ram_we_d;
         ram_re_q         <= ram_re_d;
         ram_word_addr_q  <= ram_word_addr_d;
         ram_wr_data_q    <= ram_wr_data_d;
         ram_wr_byte_en_q <= ram_wr_byte_en_d;
         rd_ack_q         <= rd_ack_d;
         wr_ack_q         <= wr_ack_d;
         err_q            <= err_d;
         rd_data_q        <= rd_data_d;
         busy_q           <= busy_d;
      end
   end

   assign o_rd_ack         = rd_ack_q;
   assign o_wr_ack         = wr_ack_q;
   assign o_err            = err_q;
   assign o_rd_data        = rd_data_q;
   assign o_busy           = busy_q;
   assign o_ram_we         = ram_we_q;
   assign o_ram_re         = ram_re_q;
   assign o_ram_word_addr  = ram_word_addr_q;
   assign o_ram_wr_data    = ram_wr_data_q;
   assign o_ram_wr_byte_en = ram_wr_byte_en_q;

endmodule

// File: tb/tb_csr_to_mbram_bridge.sv
// Directed bench for csr_to_mbram_bridge (32-bit words, 3 banks of 8, latency 2).
module tb_csr_to_mbram_bridge;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rst_n, acc_req, is_wr;
   logic [6:0]  byte_addr;
   logic [31:0] wr_data, bit_en, rd_data, ram_wr_data;
   logic        rd_ack, wr_ack, err, busy;
   logic [2:0]  ram_we, ram_re, ram_word_addr;
   logic [3:0]  ram_wr_byte_en;
   logic [95:0] ram_rd_data;

   int n_checks = 0;
   int n_errors = 0;

   // RAM model state
   logic [31:0] mem [3][8];
   logic [2:0]  re_h [L];
   logic [2:0]  addr_h [L];

   // captured observations, index = cycle after acceptance
   logic [2:0]  ob_we [1:8];
   logic [2:0]  ob_re [1:8];
   logic [2:0]  ob_wa [1:8];
   logic        ob_rd_ack [1:8];
   logic        ob_wr_ack [1:8];
   logic        ob_err [1:8];
   logic        ob_busy [1:8];
   logic [31:0] ob_rd_data [1:8];
   logic [31:0] ob_wdata [1:8];
   logic [3:0]  ob_be [1:8];

   always #5 clk = ~clk;

   csr_to_mbram_bridge dut (
      .i_clk            (clk),
      .i_async_rst_n    (rst_n),
      .i_acc_req        (acc_req),
      .i_byte_addr      (byte_addr),
      .i_acc_req_is_wr  (is_wr),
      .i_wr_data        (wr_data),
      .i_wr_bit_en      (bit_en),
      .o_rd_ack         (rd_ack),
      .o_wr_ack         (wr_ack),
      .o_err            (err),
      .o_rd_data        (rd_data),
      .o_busy           (busy),
      .o_ram_we         (ram_we),
      .o_ram_re         (ram_re),
      .o_ram_word_addr  (ram_word_addr),
      .o_ram_wr_data    (ram_wr_data),
      .o_ram_wr_byte_en (ram_wr_byte_en),
      .i_ram_rd_data    (ram_rd_data)
   );

   // RAM model: read data valid L cycles after the strobe, byte-enabled writes
   always @(posedge clk) begin
      re_h[0]   <= ram_re;
      addr_h[0] <= ram_word_addr;
      for (int i = 1; i < L; i++) begin
         re_h[i]   <= re_h[i-1];
         addr_h[i] <= addr_h[i-1];
      end
      for (int k = 0; k < 3; k++) begin
         if (ram_we[k]) begin
            for (int b = 0; b < 4; b++) begin
               if (ram_wr_byte_en[b]) mem[k][ram_word_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
            end
         end
      end
   end

   // Drive per-bank read data; garbage outside the valid cycle
   always_comb begin
      ram_rd_data = '0;
      for (int k = 0; k < 3; k++) begin
         ram_rd_data[k*32 +: 32] = re_h[L-1][k] ? mem[k][addr_h[L-1]] : 32'hBAD0_0000;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // present a request for the next edge, then scramble inputs after acceptance
   task automatic issue(input logic wr, input logic [6:0] addr, input logic [31:0] d, input logic [31:0] be);
      acc_req = 1'b1; is_wr = wr; byte_addr = addr; wr_data = d; bit_en = be;
      @(posedge clk); #1;
      acc_req = 1'b0; byte_addr = addr ^ 7'h5A; wr_data = ~d; bit_en = ~be;
   endtask

   // sample outputs in cycles 1..n after acceptance
   task automatic capture(input int n, input int drop_at);
      for (int c = 1; c <= n; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         ob_we[c] = ram_we; ob_re[c] = ram_re; ob_wa[c] = ram_word_addr;
         ob_rd_ack[c] = rd_ack; ob_wr_ack[c] = wr_ack; ob_err[c] = err; ob_busy[c] = busy;
         ob_rd_data[c] = rd_data; ob_wdata[c] = ram_wr_data; ob_be[c] = ram_wr_byte_en;
         if (c == drop_at) acc_req = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks, wacks, wes;
      for (int k = 0; k < 3; k++) for (int a = 0; a < 8; a++) mem[k][a] = 32'h0;
      mem[0][1] = 32'h1234_5678;
      mem[0][2] = 32'h1122_3344;
      rst_n = 1'b0; acc_req = 1'b0; is_wr = 1'b0; byte_addr = 7'h0; wr_data = 32'h0; bit_en = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_strobes", {ram_we, ram_re}, 6'h0);
      check_val("rst_acks", {rd_ack, wr_ack, err}, 3'h0);
      check_val("rst_rd_data", rd_data, 32'h0);

      // reset release with a full write held: ignored at edge 1, accepted at edge 2
      @(negedge clk);
      rst_n = 1'b1;
      acc_req = 1'b1; is_wr = 1'b1; byte_addr = 7'h44; wr_data = 32'hDEAD_BEEF; bit_en = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      check_val("sync_edge1_ack", wr_ack, 1'b0);
      check_val("sync_edge1_we", ram_we, 3'b000);
      @(posedge clk); #1;
      acc_req = 1'b0; byte_addr = 7'h00; wr_data = 32'h0;
      check_val("wr_we", ram_we, 3'b100);
      check_val("wr_word_addr", ram_word_addr, 3'd1);
      check_val("wr_byte_en", ram_wr_byte_en, 4'hF);
      check_val("wr_data", ram_wr_data, 32'hDEAD_BEEF);
      check_val("wr_ack_c1", {wr_ack, err, busy}, 3'b101);
      @(posedge clk); #1;
      check_val("wr_c2_quiet", {ram_we, wr_ack, busy}, 5'h0);

      // full read, ack at cycle 2+L
      issue(1'b0, 7'h44, 32'h0, 32'h0);
      capture(5, 0);
      check_val("rd_re_c1", ob_re[1], 3'b100);
      check_val("rd_wa_c1", ob_wa[1], 3'd1);
      check_val("rd_re_c2", ob_re[2], 3'b000);
      check_val("rd_ack_c3", ob_rd_ack[3], 1'b0);
      check_val("rd_ack_c4", ob_rd_ack[4], 1'b1);
      check_val("rd_data_c4", ob_rd_data[4], 32'hDEAD_BEEF);
      check_val("rd_ack_c5", ob_rd_ack[5], 1'b0);
      check_val("rd_hold_c5", ob_rd_data[5], 32'hDEAD_BEEF);
      check_val("rd_busy_c4_c5", {ob_busy[4], ob_busy[5]}, 2'b10);

      // read-modify-write on a single nibble
      issue(1'b1, 7'h04, 32'h0000_000F, 32'h0000_000F);
      capture(5, 0);
      check_val("rmw_re_c1", ob_re[1], 3'b001);
      check_val("rmw_no_we_c1_c3", {ob_we[1], ob_we[2], ob_we[3]}, 9'h0);
      check_val("rmw_ack_c3", ob_wr_ack[3], 1'b0);
      check_val("rmw_we_c4", ob_we[4], 3'b001);
      check_val("rmw_data_c4", ob_wdata[4], 32'h1234_567F);
      check_val("rmw_be_c4", ob_be[4], 4'hF);
      check_val("rmw_ack_c4", ob_wr_ack[4], 1'b1);
      check_val("rmw_c5", {ob_we[5], ob_wr_ack[5], ob_busy[5]}, 5'h0);

      // RMW mixing full, empty and partial lanes
      issue(1'b1, 7'h08, 32'hAABB_CCDD, 32'hFF00_F0F0);
      capture(5, 0);
      check_val("rmw2_we_c4", ob_we[4], 3'b001);
      check_val("rmw2_wa_c4", ob_wa[4], 3'd2);
      check_val("rmw2_data_c4", ob_wdata[4], 32'hAA22_C3D4);

      // whole-lane write on the low half only
      issue(1'b1, 7'h20, 32'h1122_3344, 32'h0000_FFFF);
      capture(2, 0);
      check_val("half_we_c1", ob_we[1], 3'b010);
      check_val("half_be_c1", ob_be[1], 4'b0011);
      check_val("half_wa_c1", ob_wa[1], 3'd0);
      check_val("half_ack_c1", ob_wr_ack[1], 1'b1);

      // write with all bit enables clear
      issue(1'b1, 7'h24, 32'h5555_5555, 32'h0);
      capture(2, 0);
      check_val("zero_be_strobes", {ob_we[1], ob_re[1]}, 6'h0);
      check_val("zero_be_ack", {ob_wr_ack[1], ob_err[1], ob_wr_ack[2]}, 3'b100);

      // out-of-range read
      issue(1'b0, 7'h60, 32'h0, 32'h0);
      capture(2, 0);
      check_val("oor_rd_strobes", {ob_we[1], ob_re[1]}, 6'h0);
      check_val("oor_rd_ack_err", {ob_rd_ack[1], ob_err[1]}, 2'b11);
      check_val("oor_rd_data", ob_rd_data[1], 32'h0);
      check_val("oor_rd_c2", {ob_rd_ack[2], ob_err[2]}, 2'b00);

      // out-of-range write
      issue(1'b1, 7'h7C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      capture(2, 0);
      check_val("oor_wr_we", ob_we[1], 3'b000);
      check_val("oor_wr_ack_err", {ob_wr_ack[1], ob_err[1]}, 2'b11);

      // requests while in RD_WAIT are ignored
      issue(1'b0, 7'h44, 32'h0, 32'h0);
      acc_req = 1'b1; is_wr = 1'b1; byte_addr = 7'h44; wr_data = 32'h0; bit_en = 32'hFFFF_FFFF;
      capture(7, 4);
      acks = 0; wacks = 0; wes = 0;
      for (int c = 1; c <= 7; c++) begin
         acks += int'(ob_rd_ack[c]);
         wacks += int'(ob_wr_ack[c]);
         wes += int'(|ob_we[c]);
      end
      check_val("busy_rd_acks", acks, 1);
      check_val("busy_wr_acks", wacks, 0);
      check_val("busy_we", wes, 0);
      check_val("busy_rd_data", ob_rd_data[4], 32'hDEAD_BEEF);

      // reset in cycle 2 of an RMW
      issue(1'b1, 7'h04, 32'h0000_00A0, 32'h0000_00F0);
      capture(1, 0);
      check_val("rst_rmw_re_c1", ob_re[1], 3'b001);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check_val("rst_mid_busy", busy, 1'b0);
      check_val("rst_mid_rd_data", rd_data, 32'h0);
      check_val("rst_mid_wr_data", ram_wr_data, 32'h0);
      check_val("rst_mid_misc", {ram_we, ram_re, ram_word_addr, ram_wr_byte_en, rd_ack, wr_ack, err}, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      wes = 0; acks = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         wes += int'(|ram_we);
         acks += int'(rd_ack | wr_ack);
      end
      check_val("rst_rmw_no_we", wes, 0);
      check_val("rst_rmw_no_ack", acks, 0);
      check_val("rst_rmw_mem", mem[0][1], 32'h1234_567F);

      // normal operation after reset
      issue(1'b0, 7'h04, 32'h0, 32'h0);
      capture(5, 0);
      check_val("post_rst_rd_ack", ob_rd_ack[4], 1'b1);
      check_val("post_rst_rd_data", ob_rd_data[4], 32'h1234_567F);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/csr_to_mbram_bridge.md
CSR_TO_MBRAM_BRIDGE -- requirements
Module: csr_to_mbram_bridge

Interface
REQ-001 Parameter WORD_BIT_WIDTH, default 32: CSR/RAM word width; SHALL be a power of 2, at least 8.
REQ-002 Parameter NUM_BANKS, default 3: RAM bank count, 1..16, not necessarily a power of 2.
REQ-003 Parameter BANK_DEPTH, default 8: words per bank; SHALL be a power of 2.
REQ-004 Parameter RAM_RD_LATENCY, default 2: cycles from o_ram_re to valid i_ram_rd_data, 1..8.
REQ-005 Derived constants: BYTES = WORD_BIT_WIDTH/8; WA_W = clog2(BANK_DEPTH); BK_W = clog2(NUM_BANKS), minimum 1; BYTE_ADDR_BIT_WIDTH = BK_W + WA_W + clog2(BYTES).
REQ-006 One clock; reset is asynchronous and active-low. Ports are i_clk and i_async_rst_n.
REQ-007 i_clk  in  1  clock.
REQ-008 i_async_rst_n  in  1  asynchronous active-low reset.
REQ-009 i_acc_req  in  1  one-cycle access request.
REQ-010 i_byte_addr  in  BYTE_ADDR_BIT_WIDTH  byte address; low clog2(BYTES) bits ignored.
REQ-011 i_acc_req_is_wr  in  1  1 = write, 0 = read.
REQ-012 i_wr_data, i_wr_bit_en  in  WORD_BIT_WIDTH each  write data and per-bit enable.
REQ-013 o_rd_ack, o_wr_ack, o_err  out  1 each  completion pulses; o_err flags an out-of-range address.
REQ-014 o_rd_data  out  WORD_BIT_WIDTH  read data.
REQ-015 o_busy  out  1  high whenever the FSM is not IDLE.
REQ-016 o_ram_we, o_ram_re  out  NUM_BANKS each  one-hot per-bank write and read strobes.
REQ-017 o_ram_word_addr  out  WA_W  shared word address.
REQ-018 o_ram_wr_data  out  WORD_BIT_WIDTH  shared write data.
REQ-019 o_ram_wr_byte_en  out  BYTES  shared byte enables.
REQ-020 i_ram_rd_data  in  NUM_BANKS*WORD_BIT_WIDTH  per-bank read data; bank k occupies slice k.

Function
REQ-021 Address decode: word index = i_byte_addr >> clog2(BYTES); bank = upper BK_W bits; word address = lower WA_W bits.
REQ-022 FSM states: IDLE, RD_WAIT, RMW_WAIT, RMW_WR, DONE. Requests are accepted only in IDLE; i_acc_req outside IDLE is ignored and produces no ack.
REQ-023 All RAM-side outputs are registered. For a request sampled at cycle 0, strobes appear at cycle 1 and are high for exactly one cycle.
REQ-024 Out-of-range access (bank >= NUM_BANKS):
  - no strobe is issued;
  - the matching ack and o_err pulse at cycle 1;
  - on a read, o_rd_data = 0.
REQ-025 Read: o_ram_re[bank] at cycle 1. The FSM enters RD_WAIT and a down-counter loaded with RAM_RD_LATENCY decrements each cycle. The bank's data is captured at cycle 1+L. o_rd_data and the o_rd_ack pulse appear at cycle 2+L.
REQ-026 Write, all bit-enable bytes either all-1 or all-0:
  - o_ram_we[bank] at cycle 1, with o_ram_wr_byte_en set to the full-byte lanes;
  - o_wr_ack pulses at cycle 1.
REQ-027 Write, any byte partially enabled (read-modify-write):
  - o_ram_re[bank] at cycle 1, then RMW_WAIT for L cycles;
  - merged word = (old AND NOT bit_en) OR (wr_data AND bit_en);
  - merged word written with all byte enables at cycle 2+L, with o_wr_ack in the same cycle.
REQ-028 Write with i_wr_bit_en = 0: no strobe is issued; o_wr_ack pulses at cycle 1.
REQ-029 The address, write data and bit enables are latched at acceptance; input changes after acceptance have no effect.
REQ-030 Acks and o_err are single-cycle pulses. o_rd_data holds its value until the next o_rd_ack.
REQ-031 The FSM returns to IDLE in the cycle after the ack (state DONE), so back-to-back requests are spaced at least two cycles apart.

Reset
REQ-032 While i_async_rst_n = 0, all outputs are 0, the FSM is in IDLE and the counter is 0, asynchronously.
REQ-033 Reset during RD_WAIT or RMW_WAIT abandons the access: no write is issued and no ack is produced.
REQ-034 Reset release is synchronised internally. The first request is accepted on the second rising edge after deassertion.

Structure
REQ-035 Package csr_to_mbram_bridge_pkg SHALL hold:
  - the state enum;
  - function to_byte_en (returns full-byte lanes plus a partial-lane flag);
  - function merge_bits.
REQ-036 The read-latency counter is a sub-module, rd_lat_timer (load, count, done), parametrised by its maximum latency.
REQ-037 Parameter validation rejects illegal values at elaboration.

Verification (WORD_BIT_WIDTH=32, NUM_BANKS=3, BANK_DEPTH=8, L=2)
REQ-038 Write addr 0x44, data 0xDEADBEEF, bit_en 0xFFFFFFFF -> o_ram_we=3'b100, word_addr 1, byte_en 4'hF, o_wr_ack at cycle 1.
REQ-039 Read addr 0x44 with the RAM returning 0xDEADBEEF -> o_ram_re=3'b100 at cycle 1; o_rd_ack with o_rd_data 0xDEADBEEF at cycle 4.
REQ-040 RMW on addr 0x04 (old value 0x12345678), data 0x0000000F, bit_en 0x0000000F -> re at cycle 1, we at cycle 4 with data 0x1234567F and byte_en 4'hF, o_wr_ack at cycle 4.
REQ-041 Read addr 0x60 (bank 3) -> no strobes; o_rd_ack and o_err at cycle 1; o_rd_data 0.
REQ-042 i_acc_req asserted in RD_WAIT -> ignored, with exactly one ack observed.
REQ-043 Reset asserted at cycle 2 of an RMW -> outputs 0 immediately, and no we is issued after release.
